// File: rtl/shift_register_n_if.sv
// Bus for shift_register_n: parallel load, shift request with amount/mode,
// serial fill, and the registered word/handshake outputs.
interface shift_register_n_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             load_n;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [2:0]       mode;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output load_n, load_val, start, amount, mode, serial_in,
    input  q, serial_out, busy, done
  );

  modport slave (
    input  load_n, load_val, start, amount, mode, serial_in,
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/shift_register_n.sv
// Multi-mode WIDTH-bit shift/rotate register: parallel load, then one bit per
// clock for a latched amount under a start/busy/done handshake.
module shift_register_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic             clk,
  input logic             reset_n,
  shift_register_n_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    MODE_SRL = 3'd0,
    MODE_SLL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROR = 3'd3,
    MODE_ROL = 3'd4
  } mode_t;

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] q_r;
  logic             so_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] step_q;
  logic             step_so;

  // One single-bit step of the latched mode applied to the current word.
  always_comb begin
    // NOTE: defaults come first so every path assigns step_q/step_so and no latch is inferred.
    step_q  = q_r;
    step_so = so_r;
    case (mode_q)
      MODE_SRL: begin
        step_q  = {bus.serial_in, q_r[WIDTH-1:1]};
        step_so = q_r[0];
      end
      MODE_SLL: begin
        step_q  = {q_r[WIDTH-2:0], bus.serial_in};
        step_so = q_r[WIDTH-1];
      end
      MODE_SRA: begin
        step_q  = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        step_so = q_r[0];
      end
      MODE_ROR: begin
        step_q  = {q_r[0], q_r[WIDTH-1:1]};
        step_so = q_r[0];
      end
      MODE_ROL: begin
        step_q  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        step_so = q_r[WIDTH-1];
      end
      default: begin
        step_q  = q_r;
        step_so = so_r;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= '0;
      q_r    <= '0;
      so_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.load_n) begin
            q_r <= bus.load_val;
          end else if (bus.start) begin
            if (bus.amount == '0) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end else begin
              cnt    <= bus.amount;
              mode_q <= bus.mode;
              busy_r <= 1'b1;
              state  <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          // A load mid-operation aborts without a done pulse.
          if (!bus.load_n) begin
            q_r    <= bus.load_val;
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            q_r  <= step_q;
            so_r <= step_so;
            cnt  <= cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.serial_out = so_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_shift_register_n.sv
// Self-checking bench for shift_register_n: directed scenarios plus randomized
// operations compared against an arithmetic model of whole multi-step shifts.
module tb_shift_register_n;

  localparam int W  = 8;
  localparam int AW = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [W-1:0] mq;
  logic         mso;

  shift_register_n_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  shift_register_n #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Word after a steps of mode m, computed in one go from the mode's meaning.
  function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input logic [2:0] m,
                                               input int a, input logic sin);
    logic [W-1:0] ones;
    logic [W-1:0] r;
    int           rot;
    ones = '1;
    rot  = a % W;
    case (m)
      3'd0: r = (d >> a) | (sin ? ~(ones >> a) : '0);
      3'd1: r = (d << a) | (sin ? ~(ones << a) : '0);
      3'd2: r = $signed(d) >>> a;
      3'd3: r = (rot == 0) ? d : ((d >> rot) | (d << (W - rot)));
      3'd4: r = (rot == 0) ? d : ((d << rot) | (d >> (W - rot)));
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    bus.load_n   = 1'b0;
    bus.load_val = v;
    tick();
    bus.load_n = 1'b1;
    mq = v;
    checks++;
    if (bus.q !== v) begin
      errors++;
      $display("FAIL load: q=%h expected %h", bus.q, v);
    end
  endtask

  // Full operation from the start edge through return to IDLE.
  task automatic run_op(input logic [2:0] m, input int a, input logic sin,
                        input bit poke, input string tag);
    logic [W-1:0] exp_q;
    logic         exp_so;
    int           busy_cnt;
    int           done_cnt;
    int           done_idx;
    exp_q  = (a == 0) ? mq : model_shift(mq, m, a, sin);
    exp_so = mso;
    if (a > 0 && m <= 3'd4) begin
      logic [W-1:0] pre;
      pre    = model_shift(mq, m, a - 1, sin);
      exp_so = (m == 3'd1 || m == 3'd4) ? pre[W-1] : pre[0];
    end
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = -1;
    bus.start     = 1'b1;
    bus.amount    = AW'(a);
    bus.mode      = m;
    bus.serial_in = sin;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j <= a + 2; j++) begin
      if (j > 0) tick();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = j;
      end
      if (poke && a >= 1 && j == 1) begin
        bus.start  = 1'b1;
        bus.amount = AW'($urandom_range(0, 15));
        bus.mode   = 3'($urandom_range(0, 7));
      end
      if (j == 2) bus.start = 1'b0;
    end
    mq  = exp_q;
    mso = exp_so;
    checks++;
    if (bus.q !== exp_q) begin
      errors++;
      $display("FAIL %s q: got %h expected %h (mode %0d amt %0d)", tag, bus.q, exp_q, m, a);
    end
    checks++;
    if (bus.serial_out !== exp_so) begin
      errors++;
      $display("FAIL %s serial_out: got %b expected %b", tag, bus.serial_out, exp_so);
    end
    checks++;
    if (busy_cnt !== a) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", tag, busy_cnt, a);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done pulses: got %0d expected 1", tag, done_cnt);
    end
    checks++;
    if (done_idx !== a) begin
      errors++;
      $display("FAIL %s done timing: got cycle %0d expected %0d", tag, done_idx, a);
    end
  endtask

  // Idle for n cycles, requiring busy and done to stay low throughout.
  task automatic quiet_cycles(input int n, input string tag);
    int seen;
    seen = 0;
    for (int j = 0; j < n; j++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL %s quiet: busy/done high in %0d cycles expected 0", tag, seen);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (bus.q !== '0 || bus.serial_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset: q=%h so=%b busy=%b done=%b expected 00/0/0/0",
               bus.q, bus.serial_out, bus.busy, bus.done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mq  = '0;
    mso = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    do_load(8'hA5);
    bus.start  = 1'b1;
    bus.amount = 4'd3;
    bus.mode   = 3'd3;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.q !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.serial_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: q=%h busy=%b done=%b so=%b expected 00/0/0/0",
               bus.q, bus.busy, bus.done, bus.serial_out);
    end
    #3;
    reset_n = 1'b1;
    mq  = '0;
    mso = 1'b0;
    quiet_cycles(6, "reset_mid_shift");
  endtask

  task automatic test_serial_fill();
    do_load(8'h81);
    run_op(3'd0, 2, 1'b1, 1'b0, "srl_fill");
    checks++;
    if (bus.q !== 8'hE0 || bus.serial_out !== 1'b0) begin
      errors++;
      $display("FAIL srl_fill const: q=%h so=%b expected e0/0", bus.q, bus.serial_out);
    end
    run_op(3'd1, 1, 1'b0, 1'b0, "sll_fill");
    checks++;
    if (bus.q !== 8'hC0 || bus.serial_out !== 1'b1) begin
      errors++;
      $display("FAIL sll_fill const: q=%h so=%b expected c0/1", bus.q, bus.serial_out);
    end
  endtask

  task automatic test_sra_amount();
    do_load(8'h90);
    run_op(3'd2, 3, 1'b0, 1'b0, "sra3");
    checks++;
    if (bus.q !== 8'hF2) begin
      errors++;
      $display("FAIL sra3 const: q=%h expected f2", bus.q);
    end
    do_load(8'h90);
    run_op(3'd2, 15, 1'b1, 1'b0, "sra15");
    checks++;
    if (bus.q !== 8'hFF) begin
      errors++;
      $display("FAIL sra15 const: q=%h expected ff", bus.q);
    end
  endtask

  task automatic test_rotate_wrap();
    do_load(8'h01);
    run_op(3'd4, 9, 1'b1, 1'b0, "rol9");
    checks++;
    if (bus.q !== 8'h02) begin
      errors++;
      $display("FAIL rol9 const: q=%h expected 02", bus.q);
    end
    run_op(3'd3, 8, 1'b1, 1'b0, "ror8");
    checks++;
    if (bus.q !== 8'h02 || bus.serial_out !== 1'b0) begin
      errors++;
      $display("FAIL ror8 const: q=%h so=%b expected 02/0", bus.q, bus.serial_out);
    end
  endtask

  task automatic test_handshake();
    logic [W-1:0] v;
    do_load(8'h5A);
    run_op(3'd1, 0, 1'b1, 1'b0, "amt0");
    checks++;
    if (bus.q !== 8'h5A) begin
      errors++;
      $display("FAIL amt0 const: q=%h expected 5a", bus.q);
    end
    run_op(3'd0, 4, 1'b0, 1'b1, "start_while_busy");
    v = 8'($urandom);
    bus.load_n   = 1'b0;
    bus.load_val = v;
    bus.start    = 1'b1;
    bus.amount   = 4'd5;
    bus.mode     = 3'd0;
    tick();
    bus.load_n = 1'b1;
    bus.start  = 1'b0;
    mq = v;
    checks++;
    if (bus.q !== v || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_and_start: q=%h busy=%b expected %h/0", bus.q, bus.busy, v);
    end
    quiet_cycles(7, "load_and_start");
  endtask

  task automatic test_abort();
    logic [W-1:0] pre;
    do_load(8'hFF);
    bus.start     = 1'b1;
    bus.amount    = 4'd6;
    bus.mode      = 3'd1;
    bus.serial_in = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.load_n   = 1'b0;
    bus.load_val = 8'h3C;
    tick();
    bus.load_n = 1'b1;
    pre = model_shift(8'hFF, 3'd1, 1, 1'b0);
    mq  = 8'h3C;
    mso = pre[W-1];
    checks++;
    if (bus.q !== 8'h3C || bus.busy !== 1'b0 || bus.serial_out !== mso) begin
      errors++;
      $display("FAIL abort: q=%h busy=%b so=%b expected 3c/0/%b",
               bus.q, bus.busy, bus.serial_out, mso);
    end
    quiet_cycles(8, "abort");
    run_op(3'd3, 3, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) do_load(8'($urandom));
      run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    mq            = '0;
    mso           = 1'b0;
    reset_n       = 1'b0;
    bus.load_n    = 1'b1;
    bus.load_val  = '0;
    bus.start     = 1'b0;
    bus.amount    = '0;
    bus.mode      = '0;
    bus.serial_in = 1'b0;

    test_reset();
    test_reset_mid_shift();
    test_serial_fill();
    test_sra_amount();
    test_rotate_wrap();
    test_handshake();
    test_abort();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
